// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined RISC-V immediate generator.
// Holds the immediate format encoding (same encoding on in_imm_src and out_fmt), the base
// RV opcodes used by the auto-decoder, and the per-entry metadata record stored in the output
// FIFO alongside the immediate and the tag.
package imm_pkg;

  // Format encoding: values 6 and 7 on the select input are invalid; 7 on out_fmt means "none".
  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_Z    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  // RV32/RV64 base opcodes (instr[6:0]).
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // Width-independent part of a FIFO entry. The full entry adds imm[XLEN] and tag[TAG_W];
  // packages cannot take parameters, so the top composes it from this record.
  typedef struct packed {
    logic [2:0] fmt;
    logic       err;
  } imm_meta_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor.
// Ports:
//   instr_i   [31:0]      instruction word
//   imm_src_i [2:0]       controller format select (ignored when AUTO_DECODE=1)
//   imm_o     [XLEN-1:0]  extended immediate (0 when no format applies)
//   fmt_o     [2:0]       format used, FMT_NONE when none/illegal
//   err_o                 illegal select or unknown opcode
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          AUTO_DECODE = 1'b0
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      imm_src_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            err_o
);

  logic [6:0]        opcode;
  logic              sign;
  logic [2:0]        fmt_sel;
  logic              err_sel;
  logic signed [31:0] raw;

  assign opcode = instr_i[6:0];
  assign sign   = instr_i[31];

  // Only one of opcode/funct3 or imm_src matters for a given AUTO_DECODE setting.
  logic unused_sel;
  assign unused_sel = ^{instr_i[14:12], opcode, imm_src_i};

  always_comb begin
    fmt_sel = FMT_NONE;
    err_sel = 1'b1;
    if (AUTO_DECODE) begin
      case (opcode)
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_OP_IMM_32: begin
          fmt_sel = FMT_I;
          err_sel = 1'b0;
        end
        OPC_STORE: begin
          fmt_sel = FMT_S;
          err_sel = 1'b0;
        end
        OPC_BRANCH: begin
          fmt_sel = FMT_B;
          err_sel = 1'b0;
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt_sel = FMT_U;
          err_sel = 1'b0;
        end
        OPC_JAL: begin
          fmt_sel = FMT_J;
          err_sel = 1'b0;
        end
        OPC_SYSTEM: begin
          // funct3[2] set selects the CSR*I forms whose rs1 field is a 5-bit zimm.
          fmt_sel = instr_i[14] ? FMT_Z : FMT_I;
          err_sel = 1'b0;
        end
        // R-type is legal but carries no immediate.
        OPC_OP, OPC_OP_32: err_sel = 1'b0;
        default: ;
      endcase
    end else if (imm_src_i <= FMT_Z) begin
      fmt_sel = imm_src_i;
      err_sel = 1'b0;
    end
  end

  // Build a 32-bit signed immediate, then widen by sign extension; zimm is non-negative in
  // this form so the same widening gives zero extension for it.
  always_comb begin
    raw = '0;
    case (fmt_sel)
      FMT_I: raw = {{20{sign}}, instr_i[31:20]};
      FMT_S: raw = {{20{sign}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: raw = {{20{sign}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U: raw = {instr_i[31:12], 12'b0};
      FMT_J: raw = {{12{sign}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      FMT_Z: raw = {27'b0, instr_i[19:15]};
      default: raw = '0;
    endcase
  end

  assign imm_o = XLEN'(raw);
  assign fmt_o = fmt_sel;
  assign err_o = err_sel;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes accepted instructions and queues
// {imm, fmt, err, tag} in a 2-entry FIFO whose head drives the out_* ports.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                input handshake (in_ready from registered state only)
//   in_instr, in_imm_src, in_tag     instruction, format select, sideband tag
//   out_valid/out_ready              output handshake for the head entry
//   out_imm, out_fmt, out_err, out_tag  head entry fields
//   err_count                        saturating count of accepted entries flagged err
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          AUTO_DECODE = 1'b0,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] err_count
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_meta_t        meta;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_err;
  entry_t          dec_entry;

  imm_decode #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_decode (
    .instr_i   (in_instr),
    .imm_src_i (in_imm_src),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .err_o     (dec_err)
  );

  assign dec_entry = '{imm: dec_imm, meta: '{fmt: dec_fmt, err: dec_err}, tag: in_tag};

  entry_t           mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             push, pop;
  entry_t           head;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && dec_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      err_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= dec_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_imm   = head.imm;
  assign out_fmt   = head.meta.fmt;
  assign out_err   = head.meta.err;
  assign out_tag   = head.tag;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: instance "a" is XLEN=32 with controller select, instance "b" is XLEN=64
// with opcode auto-decode. A vector table covers extraction; hand sequences cover FIFO
// backpressure and asynchronous reset.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
  logic [31:0] a_instr, a_imm;
  logic [2:0]  a_src, a_fmt;
  logic [4:0]  a_tag, a_otag;
  logic [15:0] a_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
  logic [31:0] b_instr;
  logic [63:0] b_imm;
  logic [2:0]  b_src, b_fmt;
  logic [4:0]  b_tag, b_otag;
  logic [15:0] b_cnt;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(5), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_instr), .in_imm_src(a_src), .in_tag(a_tag), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_imm(a_imm), .out_fmt(a_fmt), .out_err(a_err),
    .out_tag(a_otag), .err_count(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1), .TAG_W(5), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_instr), .in_imm_src(b_src), .in_tag(b_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_imm(b_imm), .out_fmt(b_fmt), .out_err(b_err),
    .out_tag(b_otag), .err_count(b_cnt)
  );

  typedef struct {
    bit          is64;
    logic [2:0]  src;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        err;
  } vec_t;

  vec_t        vecs[$];
  vec_t        v;
  logic [4:0]  tg;
  int          n_vec  = 0;
  int          n_fail = 0;
  int          n_cmp  = 0;
  logic [15:0] exp_a  = '0;
  logic [15:0] exp_b  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Instance a: controller-selected format, XLEN=32 (imm column holds the 32-bit result).
    vecs.push_back('{1'b0, 3'd0, 32'hFFF00093, 64'hFFFFFFFF, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 32'h02A00513, 64'h0000002A, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 3'd1, 32'hFE112E23, 64'hFFFFFFFC, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 32'hFE000CE3, 64'hFFFFFFF8, 3'd2, 1'b0});
    vecs.push_back('{1'b0, 3'd3, 32'h12345037, 64'h12345000, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 3'd3, 32'h80000137, 64'h80000000, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 3'd4, 32'h0080006F, 64'h00000008, 3'd4, 1'b0});
    vecs.push_back('{1'b0, 3'd4, 32'hFFDFF06F, 64'hFFFFFFFC, 3'd4, 1'b0});
    vecs.push_back('{1'b0, 3'd5, 32'h300FD073, 64'h0000001F, 3'd5, 1'b0});
    vecs.push_back('{1'b0, 3'd6, 32'hFFFFFFFF, 64'h00000000, 3'd7, 1'b1});
    vecs.push_back('{1'b0, 3'd7, 32'h00000013, 64'h00000000, 3'd7, 1'b1});
    // Instance b: auto-decode, XLEN=64; src driven to an invalid code to show it is ignored.
    vecs.push_back('{1'b1, 3'd6, 32'h80000137, 64'hFFFFFFFF_80000000, 3'd3, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'h300FD073, 64'h00000000_0000001F, 3'd5, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'h0000007F, 64'h00000000_00000000, 3'd7, 1'b1});
    vecs.push_back('{1'b1, 3'd6, 32'h00000033, 64'h00000000_00000000, 3'd7, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'h30002073, 64'h00000000_00000300, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'hFE112E23, 64'hFFFFFFFF_FFFFFFFC, 3'd1, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'hFE000CE3, 64'hFFFFFFFF_FFFFFFF8, 3'd2, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'hFFDFF06F, 64'hFFFFFFFF_FFFFFFFC, 3'd4, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'h00001017, 64'h00000000_00001000, 3'd3, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'h0000003B, 64'h00000000_00000000, 3'd7, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 32'h00000003, 64'h00000000_00000000, 3'd0, 1'b0});

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_instr = '0; a_src = '0; a_tag = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_instr = '0; b_src = '0; b_tag = '0;

    // Reset state.
    #12;
    n_vec++;
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_imm", a_imm, 0);
    chk("rst_a_fmt", a_fmt, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_tag", a_otag, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_imm", b_imm, 0);
    chk("rst_b_cnt", b_cnt, 0);
    rst_n = 1'b1;

    // Table: one push per cycle; consecutive rows on one instance run back-to-back.
    for (int i = 0; i < vecs.size(); i++) begin
      v  = vecs[i];
      tg = 5'(i + 1);
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      if (v.is64) begin
        b_in_valid = 1'b1; b_instr = v.instr; b_src = v.src; b_tag = tg;
        if (v.err) exp_b = exp_b + 16'd1;
      end else begin
        a_in_valid = 1'b1; a_instr = v.instr; a_src = v.src; a_tag = tg;
        if (v.err) exp_a = exp_a + 16'd1;
      end
      tick();
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      n_vec++;
      if (v.is64) begin
        chk($sformatf("v%0d_valid", i), b_out_valid, 1);
        chk($sformatf("v%0d_imm", i), b_imm, v.imm);
        chk($sformatf("v%0d_fmt", i), b_fmt, v.fmt);
        chk($sformatf("v%0d_err", i), b_err, v.err);
        chk($sformatf("v%0d_tag", i), b_otag, tg);
        chk($sformatf("v%0d_cnt", i), b_cnt, exp_b);
      end else begin
        chk($sformatf("v%0d_valid", i), a_out_valid, 1);
        chk($sformatf("v%0d_imm", i), {32'b0, a_imm}, {32'b0, v.imm[31:0]});
        chk($sformatf("v%0d_fmt", i), a_fmt, v.fmt);
        chk($sformatf("v%0d_err", i), a_err, v.err);
        chk($sformatf("v%0d_tag", i), a_otag, tg);
        chk($sformatf("v%0d_cnt", i), a_cnt, exp_a);
      end
    end

    // Drain with garbage inputs while in_valid=0: nothing may be accepted or counted.
    a_instr = 32'h0000007F; a_src = 3'd7; b_instr = 32'h0000007F; b_src = 3'd7;
    tick();
    tick();
    n_vec++;
    chk("idle_a_valid", a_out_valid, 0);
    chk("idle_b_valid", b_out_valid, 0);
    chk("idle_a_cnt", a_cnt, exp_a);
    chk("idle_b_cnt", b_cnt, exp_b);

    // Backpressure: tags 1,2,3 pushed with out_ready low, then drained in order.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_src = 3'd0;
    a_tag = 5'd1; a_instr = {12'd1, 20'h00013};
    tick();
    n_vec++;
    chk("bp_ready_after1", a_in_ready, 1);
    a_tag = 5'd2; a_instr = {12'd2, 20'h00013};
    tick();
    n_vec++;
    chk("bp_ready_after2", a_in_ready, 0);
    a_tag = 5'd3; a_instr = {12'd3, 20'h00013};
    tick();
    n_vec++;
    chk("bp_ready_held", a_in_ready, 0);
    chk("bp_valid_held", a_out_valid, 1);
    chk("bp_tag_held", a_otag, 1);
    chk("bp_imm_held", a_imm, 1);
    a_out_ready = 1'b1;
    tick();
    n_vec++;
    chk("bp_pop1_tag", a_otag, 2);
    chk("bp_pop1_imm", a_imm, 2);
    chk("bp_pop1_ready", a_in_ready, 1);
    tick();
    n_vec++;
    a_in_valid = 1'b0;
    chk("bp_pop2_valid", a_out_valid, 1);
    chk("bp_pop2_tag", a_otag, 3);
    chk("bp_pop2_imm", a_imm, 3);
    tick();
    n_vec++;
    chk("bp_empty", a_out_valid, 0);
    tick();
    chk("bp_no_dup", a_out_valid, 0);

    // Asynchronous reset with two error entries buffered.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_src = 3'd7; a_tag = 5'd7;
    tick();
    a_tag = 5'd8;
    tick();
    a_in_valid = 1'b0;
    exp_a = exp_a + 16'd2;
    n_vec++;
    chk("rs_full", a_in_ready, 0);
    chk("rs_cnt_before", a_cnt, exp_a);
    #3;
    rst_n = 1'b0;
    #1;
    exp_a = '0;
    exp_b = '0;
    n_vec++;
    chk("rs_out_valid", a_out_valid, 0);
    chk("rs_in_ready", a_in_ready, 1);
    chk("rs_cnt", a_cnt, exp_a);
    chk("rs_tag", a_otag, 0);
    chk("rs_fmt", a_fmt, 0);
    chk("rs_err", a_err, 0);
    chk("rs_b_cnt", b_cnt, exp_b);
    #2;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      chk($sformatf("rs_stale%0d", k), a_out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
